// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module      : alu_exec_unit
// Description : Execution-stage ALU with valid/ready handshakes. Single-cycle
//               arithmetic/logic/compare, iterative one-bit-per-cycle shifts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cnt,
  input  logic             arith,
  input  logic             unsigned_cmp,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_SHIFT = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_XOR = 3'b010;
  localparam logic [2:0] c_OP_OR  = 3'b011;
  localparam logic [2:0] c_OP_AND = 3'b100;
  localparam logic [2:0] c_OP_SLL = 3'b101;
  localparam logic [2:0] c_OP_SRX = 3'b110;
  localparam logic [2:0] c_OP_SLT = 3'b111;

  localparam logic [SHAMT_W-1:0] c_CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q,   state_d;
  logic [WIDTH-1:0]   result_q,  result_d;
  logic               zero_q,    zero_d;
  logic               illegal_q, illegal_d;
  logic [SHAMT_W-1:0] cnt_q,     cnt_d;
  logic               shl_q,     shl_d;
  logic               sra_q,     sra_d;

  logic               w_accept;
  logic               w_is_shift;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_lt;
  logic [WIDTH-1:0]   w_alu_res;
  logic [WIDTH-1:0]   w_shifted;

  assign w_accept   = (state_q == c_ST_IDLE) && in_valid;
  assign w_is_shift = ~alu_cnt[3] &&
                      ((alu_cnt[2:0] == c_OP_SLL) || (alu_cnt[2:0] == c_OP_SRX));
  assign w_shamt    = op_b[SHAMT_W-1:0];
  assign w_lt       = unsigned_cmp ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));

  // Single-cycle result; illegal codes force zero so the zero flag reads 1.
  always_comb begin
    w_alu_res = '0;
    if (!alu_cnt[3]) begin
      case (alu_cnt[2:0])
        c_OP_ADD: w_alu_res = op_a + op_b;
        c_OP_SUB: w_alu_res = op_a - op_b;
        c_OP_XOR: w_alu_res = op_a ^ op_b;
        c_OP_OR:  w_alu_res = op_a | op_b;
        c_OP_AND: w_alu_res = op_a & op_b;
        c_OP_SLT: w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
        default:  w_alu_res = '0;
      endcase
    end
  end

  // The working register keeps its MSB on sra, so replicating it fills with the latched sign.
  assign w_shifted = shl_q ? {result_q[WIDTH-2:0], 1'b0}
                           : {sra_q & result_q[WIDTH-1], result_q[WIDTH-1:1]};

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (in_valid) begin
          if (w_is_shift && (w_shamt != '0)) begin
            state_d = c_ST_SHIFT;
          end else begin
            state_d = c_ST_DONE;
          end
        end
      end
      c_ST_SHIFT: begin
        if (cnt_q == c_CNT_ONE) begin
          state_d = c_ST_DONE;
        end
      end
      c_ST_DONE: begin
        if (out_ready) begin
          state_d = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == c_ST_IDLE) && !rst;
    out_valid = (state_q == c_ST_DONE);
  end

  // Datapath next-state
  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    shl_d     = shl_q;
    sra_d     = sra_q;
    if (w_accept) begin
      illegal_d = alu_cnt[3];
      if (w_is_shift) begin
        result_d = op_a;
        zero_d   = (op_a == '0);
        cnt_d    = w_shamt;
        shl_d    = (alu_cnt[2:0] == c_OP_SLL);
        sra_d    = arith;
      end else begin
        result_d = w_alu_res;
        zero_d   = (w_alu_res == '0);
      end
    end else if (state_q == c_ST_SHIFT) begin
      result_d = w_shifted;
      zero_d   = (w_shifted == '0);
      cnt_d    = cnt_q - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
      shl_q     <= 1'b0;
      sra_q     <= 1'b0;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      shl_q     <= shl_d;
      sra_q     <= sra_d;
    end
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int LAT_MAX = 64;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_cnt;
  logic             arith;
  logic             unsigned_cmp;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  int n_chk  = 0;
  int n_pass = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_cnt      (alu_cnt),
    .arith        (arith),
    .unsigned_cmp (unsigned_cmp),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero         (zero),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble the inputs after the accept edge, wait for out_valid.
  task automatic run_op(input string tag, input logic [3:0] cnt, input logic ar, input logic uc,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_zero, input logic exp_ill, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    in_valid     = 1'b1;
    alu_cnt      = cnt;
    arith        = ar;
    unsigned_cmp = uc;
    op_a         = a;
    op_b         = b;
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    alu_cnt      = 4'($urandom);
    arith        = 1'($urandom);
    unsigned_cmp = 1'($urandom);
    op_a         = $urandom;
    op_b         = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < LAT_MAX) begin
      chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, "_ill"}, {31'd0, illegal}, {31'd0, exp_ill});
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_ret"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    alu_cnt      = 4'd0;
    arith        = 1'b0;
    unsigned_cmp = 1'b0;
    op_a         = '0;
    op_b         = '0;
    out_ready    = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy",  {31'd0, in_ready},  32'd0);
    chk("rst_ov",   {31'd0, out_valid}, 32'd0);
    chk("rst_res",  result,             32'd0);
    chk("rst_zero", {31'd0, zero},      32'd0);
    chk("rst_ill",  {31'd0, illegal},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_rdy", {31'd0, in_ready}, 32'd1);

    run_op("add_wrap", 4'b0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
    retire("add_wrap");
    run_op("sub", 4'b0001, 1'b0, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
    retire("sub");
    run_op("slt", 4'b0111, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    retire("slt");
    run_op("sltu", 4'b0111, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    retire("sltu");
    run_op("or", 4'b0011, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'hFFF0, 1'b0, 1'b0, 1);
    retire("or");
    run_op("and", 4'b0100, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0, 1);
    retire("and");
    run_op("sra", 4'b0110, 1'b1, 1'b0, 32'h8000_0010, 32'd4, 32'hF800_0001, 1'b0, 1'b0, 5);
    retire("sra");
    run_op("srl", 4'b0110, 1'b0, 1'b0, 32'h8000_0010, 32'd4, 32'h0800_0001, 1'b0, 1'b0, 5);
    retire("srl");
    // Only the low SHAMT_W bits of op_b count as the shift amount.
    run_op("srl_hi", 4'b0110, 1'b0, 1'b0, 32'h8000_0010, 32'h24, 32'h0800_0001, 1'b0, 1'b0, 5);
    retire("srl_hi");
    run_op("sll0", 4'b0101, 1'b0, 1'b0, 32'h1234, 32'd0, 32'h1234, 1'b0, 1'b0, 1);
    retire("sll0");
    run_op("sll31", 4'b0101, 1'b0, 1'b0, 32'h1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
    retire("sll31");
    run_op("sll_out", 4'b0101, 1'b0, 1'b0, 32'h4000_0000, 32'd2, 32'h0, 1'b1, 1'b0, 3);
    retire("sll_out");

    out_ready = 1'b0;
    run_op("bp_xor", 4'b0010, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'hFF00, 1'b0, 1'b0, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_res", result, 32'hFF00);
      chk("bp_hold_hs", {30'd0, out_valid, in_ready}, 32'd2);
    end
    retire("bp_xor");

    run_op("illegal", 4'b1010, 1'b1, 1'b1, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b1, 1);
    retire("illegal");
    run_op("post_ill", 4'b0000, 1'b0, 1'b0, 32'd10, 32'd20, 32'd30, 1'b0, 1'b0, 1);
    retire("post_ill");

    @(negedge clk);
    in_valid = 1'b1;
    alu_cnt  = 4'b0101;
    op_a     = 32'h1;
    op_b     = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("abort_res", result, 32'd0);
    chk("abort_flags", {29'd0, out_valid, zero, illegal}, 32'd0);
    chk("abort_rdy", {31'd0, in_ready}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_rel_rdy", {31'd0, in_ready}, 32'd1);
    run_op("post_rst_add", 4'b0000, 1'b0, 1'b0, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
    retire("post_rst_add");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
